// File: rtl/uart_rx_if.sv
// Serial receive bundle: the rx line in, the received byte and status out.
// The slave side is the receiver, the master side drives the line and consumes bytes.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       received;
  logic       frame_error;
  logic       busy;

  modport master (
    output rx,
    input  data,
    input  received,
    input  frame_error,
    input  busy
  );

  modport slave (
    input  rx,
    output data,
    output received,
    output frame_error,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, centre sampling at CLKDIV clk/bit,
// one-cycle strobes for good bytes and for bad stop bits.
module uart_rx #(
  parameter int CLKDIV = 16
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);
  localparam int W = $clog2(CLKDIV);
  localparam logic [W-1:0] HALF_M1 = W'(CLKDIV / 2 - 1);
  localparam logic [W-1:0] LAST    = W'(CLKDIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t         state, state_d;
  logic           s1, rx_s;
  logic [W-1:0]   cnt, cnt_d;
  logic [2:0]     idx, idx_d;
  logic [7:0]     shreg, shreg_d;
  logic [7:0]     data_q, data_d;
  logic           rcv_q, rcv_d;
  logic           fe_q, fe_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= bus.rx;
      rx_s <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      data_q <= '0;
      rcv_q  <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      shreg  <= shreg_d;
      data_q <= data_d;
      rcv_q  <= rcv_d;
      fe_q   <= fe_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = (cnt == LAST) ? '0 : cnt + 1'b1;
    idx_d   = idx;
    shreg_d = shreg;
    data_d  = data_q;
    rcv_d   = 1'b0;
    fe_d    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      // half-bit check realigns the counter to bit centres
      START: begin
        if (cnt == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          shreg_d[idx] = rx_s;
          idx_d        = idx + 3'd1;
          if (idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          if (rx_s) begin
            data_d  = shreg;
            rcv_d   = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data        = data_q;
  assign bus.received    = rcv_q;
  assign bus.frame_error = fe_q;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx at CLKDIV=16 and CLKDIV=5 against an
// event-level model: each sent frame predicts one strobe at a fixed time.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if b16 ();
  uart_rx_if b5 ();

  uart_rx #(.CLKDIV(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  uart_rx #(.CLKDIV(5))  dut5  (.clk(clk), .rst(rst), .bus(b5));

  typedef struct {
    int         at;
    bit         fe;
    logic [7:0] d;
  } ev_t;

  ev_t        q16[$];
  ev_t        q5[$];
  logic [7:0] last_good[2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int cdiv(input int w);
    return (w == 0) ? 16 : 5;
  endfunction

  task automatic setrx(input int w, input logic v);
    if (w == 0) b16.rx = v;
    else b5.rx = v;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input int w, input logic v, input int n);
    setrx(w, v);
    step(n);
  endtask

  // Pin goes low in cycle cyc; the synchronised low is seen 2 cycles later
  // (t=0) and the strobe lands at t = HALF + 9*CLKDIV + 1.
  task automatic send_frame(input int w, input logic [7:0] b, input bit stop);
    int  c;
    ev_t e;
    c    = cdiv(w);
    e.at = cyc + 2 + c / 2 + 9 * c + 1;
    e.fe = !stop;
    e.d  = stop ? b : last_good[w];
    if (stop) last_good[w] = b;
    if (w == 0) q16.push_back(e);
    else q5.push_back(e);
    put(w, 1'b0, c);
    for (int i = 0; i < 8; i++) put(w, b[i], c);
    put(w, stop, c);
  endtask

  function automatic logic busy_of(input int w);
    return (w == 0) ? b16.busy : b5.busy;
  endfunction

  task automatic glitch(input int w, input int g);
    int c0, h;
    c0 = cyc;
    h  = cdiv(w) / 2;
    setrx(w, 1'b0);
    for (int i = 0; i < g + h + 5; i++) begin
      if (i == g) setrx(w, 1'b1);
      chk("busy_glitch", busy_of(w),
          (cyc - c0 >= 3) && (cyc - c0 <= 2 + h));
      step(1);
    end
    put(w, 1'b1, cdiv(w));
  endtask

  task automatic brk(input int w, input logic [7:0] b, input int hold);
    int r;
    send_frame(w, b, 1'b0);
    put(w, 1'b0, hold);
    r = cyc;
    setrx(w, 1'b1);
    step(2);
    chk("busy_brk_hi", busy_of(w), 1'b1);
    chk("brk_cyc", cyc - r, 2);
    step(1);
    chk("busy_brk_lo", busy_of(w), 1'b0);
    put(w, 1'b1, cdiv(w));
  endtask

  task automatic mon(input int w, input logic rcv, input logic fe,
                     input logic [7:0] d);
    ev_t e;
    if (rcv && fe) chk("rcv_fe_excl", 1, 0);
    if (rcv || fe) begin
      if ((w == 0 && q16.size() == 0) || (w == 1 && q5.size() == 0)) begin
        chk(w == 0 ? "unexp_evt16" : "unexp_evt5", 1, 0);
      end else begin
        e = (w == 0) ? q16.pop_front() : q5.pop_front();
        chk(w == 0 ? "evt_cyc16" : "evt_cyc5", cyc, e.at);
        chk(w == 0 ? "evt_fe16" : "evt_fe5", fe, e.fe);
        chk(w == 0 ? "data16" : "data5", d, e.d);
      end
    end
  endtask

  always @(negedge clk) mon(0, b16.received, b16.frame_error, b16.data);
  always @(negedge clk) mon(1, b5.received, b5.frame_error, b5.data);

  task automatic rand_run(input int w, input int n);
    int k, c;
    c = cdiv(w);
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0) glitch(w, $urandom_range(1, c / 2 - 1));
      else if (k == 1) brk(w, 8'($urandom), $urandom_range(0, 40));
      else begin
        send_frame(w, 8'($urandom), 1'b1);
        put(w, 1'b1, $urandom_range(0, 2 * c));
      end
    end
    put(w, 1'b1, 3 * c);
  endtask

  task automatic check_idle(input int w);
    if (w == 0) begin
      chk("rst_data16", b16.data, 8'h00);
      chk("rst_rcv16", b16.received, 1'b0);
      chk("rst_fe16", b16.frame_error, 1'b0);
      chk("rst_busy16", b16.busy, 1'b0);
    end else begin
      chk("rst_data5", b5.data, 8'h00);
      chk("rst_rcv5", b5.received, 1'b0);
      chk("rst_fe5", b5.frame_error, 1'b0);
      chk("rst_busy5", b5.busy, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] ab;
    b16.rx = 1'b1;
    b5.rx  = 1'b1;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    step(3);
    rst = 1'b0;
    step(1);
    check_idle(0);
    check_idle(1);

    send_frame(0, 8'h5C, 1'b1);
    put(0, 1'b1, 40);
    glitch(0, 4);
    brk(0, 8'hA5, 100);
    put(0, 1'b1, 20);

    for (int b = 0; b < 256; b++) send_frame(0, 8'(b), 1'b1);
    put(0, 1'b1, 40);

    rand_run(0, 30);

    send_frame(1, 8'hF0, 1'b1);
    put(1, 1'b1, 10);
    rand_run(1, 60);

    chk("pend_pre_rst16", q16.size(), 0);
    chk("pend_pre_rst5", q5.size(), 0);

    ab = 8'h3C;
    put(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) put(0, ab[i], 16);
    setrx(0, ab[4]);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    check_idle(0);
    check_idle(1);
    put(0, 1'b1, 200);
    chk("abort_data16", b16.data, 8'h00);
    send_frame(0, 8'h81, 1'b1);
    put(0, 1'b1, 40);
    chk("post_rst_data16", b16.data, 8'h81);

    chk("pend_end16", q16.size(), 0);
    chk("pend_end5", q5.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
